reflet_bus_initiator: RTL and testbench



---
 rtl/reflet_bus_pkg.sv | 15 +
 rtl/reflet_bus_initiator.sv | 113 +++++++++++
 tb/tb_reflet_bus_initiator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reflet_bus_pkg.sv
// Shared types and constants for the Reflet peripheral bus initiator.
package reflet_bus_pkg;

    localparam int unsigned BUS_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCESS   = 3'd1,
        CAPTURE  = 3'd2,
        VERIFY   = 3'd3,
        VCAPTURE = 3'd4,
        RESPOND  = 3'd5
    } state_t;

endpackage

// File: rtl/reflet_bus_initiator.sv
// Byte-wide Reflet bus initiator: one bus access per valid/ready command, response on valid/ready.
// Optional write readback verification is compiled in with REFLET_BUS_INITIATOR_READBACK_EN.
module reflet_bus_initiator
    import reflet_bus_pkg::*;
#(
    parameter int unsigned addr_size = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_size-1:0]  cmd_addr,
    input  logic [BUS_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BUS_DATA_W-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  bus_enable,
    output logic [addr_size-1:0]  bus_addr,
    output logic                  bus_write_en,
    output logic [BUS_DATA_W-1:0] bus_data_out,
    input  logic [BUS_DATA_W-1:0] bus_data_in
);

    state_t                  state;
    logic                    lat_write;
    logic [addr_size-1:0]    lat_addr;
    logic [BUS_DATA_W-1:0]   lat_wdata;

    // Command latch, sequencer and response register; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
            bus_enable   <= 1'b0;
            bus_addr     <= '0;
            bus_write_en <= 1'b0;
            bus_data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        lat_write    <= cmd_write;
                        lat_addr     <= cmd_addr;
                        lat_wdata    <= cmd_wdata;
                        cmd_ready    <= 1'b0;
                        bus_enable   <= 1'b1;
                        bus_addr     <= cmd_addr;
                        bus_write_en <= cmd_write;
                        bus_data_out <= cmd_write ? cmd_wdata : '0;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus_enable   <= 1'b0;
                    bus_addr     <= '0;
                    bus_write_en <= 1'b0;
                    bus_data_out <= '0;
                    state        <= CAPTURE;
                end
                CAPTURE: begin
                    // Writes echo their own data; reads return the peripheral's registered output.
                    rsp_data <= lat_write ? lat_wdata : bus_data_in;
`ifdef REFLET_BUS_INITIATOR_READBACK_EN
                    if (lat_write) begin
                        bus_enable <= 1'b1;
                        bus_addr   <= lat_addr;
                        state      <= VERIFY;
                    end else begin
                        rsp_error <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESPOND;
                    end
`else
                    rsp_valid <= 1'b1;
                    state     <= RESPOND;
`endif
                end
`ifdef REFLET_BUS_INITIATOR_READBACK_EN
                VERIFY: begin
                    bus_enable <= 1'b0;
                    bus_addr   <= '0;
                    state      <= VCAPTURE;
                end
                VCAPTURE: begin
                    rsp_error <= (bus_data_in != lat_wdata);
                    rsp_valid <= 1'b1;
                    state     <= RESPOND;
                end
`endif
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_bus_initiator.sv
// Randomized self-checking bench for reflet_bus_initiator with a register-file peripheral model.
module tb_reflet_bus_initiator;

`ifdef REFLET_BUS_INITIATOR_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam logic [15:0] OVR_ADDR = 16'h0020;
    localparam logic [7:0]  OVR_VAL  = 8'h22;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        rsp_error;
    logic        bus_enable;
    logic [15:0] bus_addr;
    logic        bus_write_en;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    reflet_bus_initiator #(.addr_size(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .bus_enable(bus_enable), .bus_addr(bus_addr), .bus_write_en(bus_write_en),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in)
    );

    always #5 clk = ~clk;

    // Peripheral register file: 0x00-0xFF mapped, OVR_ADDR held by an override, registered read data.
    always @(posedge clk) begin
        if (bus_enable && bus_write_en && bus_addr < 16'h0100 && bus_addr != OVR_ADDR)
            mem[bus_addr[7:0]] <= bus_data_out;
        if (bus_enable && !bus_write_en)
            bus_data_in <= (bus_addr == OVR_ADDR) ? OVR_VAL :
                           (bus_addr < 16'h0100) ? mem[bus_addr[7:0]] : 8'h00;
        else
            bus_data_in <= 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (a == OVR_ADDR) return OVR_VAL;
        if (a < 16'h0100) return ref_mem[a[7:0]];
        return 8'h00;
    endfunction

    // One command end to end: latency, bus pulses, response contents, optional back-pressure.
    task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [7:0] d, input int hold);
        logic [7:0] exp_data;
        logic       exp_err;
        int         pulses;
        int         lat;
        int         exp_lat;
        int         wait_cnt;
        logic [7:0] held;

        if (wr) begin
            if (a < 16'h0100 && a != OVR_ADDR) ref_mem[a[7:0]] = d;
            exp_data = d;
            exp_err  = RB && (model_read(a) != d);
        end else begin
            exp_data = model_read(a);
            exp_err  = 1'b0;
        end
        exp_lat = (RB && wr) ? 5 : 3;

        @(negedge clk);
        wait_cnt = 0;
        while (!cmd_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        pulses = 0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (bus_enable) begin
                pulses++;
                check("bus_addr", 32'(bus_addr), 32'(a));
                check("bus_write_en", 32'(bus_write_en), (pulses == 1) ? 32'(wr) : 32'd0);
                if (pulses == 1 && wr) check("bus_data_out", 32'(bus_data_out), 32'(d));
            end
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("bus_pulses", 32'(pulses), (RB && wr) ? 32'd2 : 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_error", 32'(rsp_error), 32'(exp_err));

        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0011;
            @(negedge clk);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_bus_enable", 32'(bus_enable), 32'd0);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_data", 32'(rsp_data), 32'(held));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] v;
        int         seen;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[8'h10] = 8'h5A;
        ref_mem[8'h10] = 8'h5A;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_bus", {bus_enable, bus_write_en, bus_addr, bus_data_out}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed cases
        do_cmd(1'b0, 16'h0010, 8'h00, 0);
        do_cmd(1'b1, 16'h0010, 8'hC3, 0);
        do_cmd(1'b0, 16'h0010, 8'h00, 0);
        do_cmd(1'b0, 16'h7FFF, 8'h00, 0);
        do_cmd(1'b0, 16'h0010, 8'h00, 10);
        do_cmd(1'b1, OVR_ADDR, 8'h11, 0);

        // Reset during ACCESS abandons the read
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("access_bus_enable", 32'(bus_enable), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_bus_enable", 32'(bus_enable), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("arst_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || bus_enable) seen++;
        end
        check("arst_no_response", 32'(seen), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0:       a = OVR_ADDR;
                1:       a = 16'($urandom_range(16'h0100, 16'hFFFF));
                default: a = 16'($urandom_range(0, 255));
            endcase
            do_cmd(1'($urandom), a, 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
